xoodyak_hash_stream: RTL

Parametrised Xoodyak hash engine (Cyclist hash mode, Xoodoo[12]). It accepts a byte stream over a valid/ready handshake and emits a HASH_BYTES-long digest over a second valid/ready handshake. Message length is unbounded; the end is marked with msg_last. The permutation unroll factor is configurable, and the block replaces the fixed 32-byte, fixed-length hash core in the crypto datapath.

---
 rtl/xoodyak_hash_stream.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/xoodyak_hash_stream.sv
// Byte-streaming Xoodyak hash (Cyclist hash mode, Xoodoo[12]) with a configurable round unroll.
// Optional XOODYAK_ZEROIZE_EN: wipe the state (and so hash_data) when the final digest byte leaves.
module xoodyak_hash_stream #(
  parameter int unsigned HASH_BYTES       = 32,
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       msg_empty,
  input  logic [7:0] msg_data,
  input  logic       msg_valid,
  input  logic       msg_last,
  output logic       msg_ready,
  output logic [7:0] hash_data,
  output logic       hash_valid,
  output logic       hash_last,
  input  logic       hash_ready,
  output logic       busy
);
  typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_DOWN, S_PERM, S_SQUEEZE, S_SDOWN} state_e;

  localparam logic [3:0] RND_STEP = 4'(ROUNDS_PER_CYCLE);
  localparam logic [3:0] RND_LAST = 4'(12 - ROUNDS_PER_CYCLE);
  localparam logic [7:0] OUT_LAST = 8'(HASH_BYTES - 1);

  state_e       fsm_q, fsm_d;
  logic [383:0] st_q, st_d, perm_s;
  logic [4:0]   cnt_q, cnt_d;
  logic [7:0]   ocnt_q, ocnt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         first_q, first_d, done_q, done_d;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] rc(input logic [3:0] r);
    case (r)
      4'd0:    rc = 32'h058;
      4'd1:    rc = 32'h038;
      4'd2:    rc = 32'h3C0;
      4'd3:    rc = 32'h0D0;
      4'd4:    rc = 32'h120;
      4'd5:    rc = 32'h014;
      4'd6:    rc = 32'h060;
      4'd7:    rc = 32'h02C;
      4'd8:    rc = 32'h380;
      4'd9:    rc = 32'h0F0;
      4'd10:   rc = 32'h1A0;
      4'd11:   rc = 32'h012;
      default: rc = '0;
    endcase
  endfunction

  // Lane (x,y) sits at bits 32*(4y+x); theta is folded into the rho-west plane shift.
  function automatic logic [383:0] xoodoo_round(input logic [383:0] s, input logic [31:0] c);
    logic [31:0]  a [12];
    logic [31:0]  b [12];
    logic [31:0]  p [4];
    logic [31:0]  e [4];
    logic [383:0] r;
    for (int unsigned i = 0; i < 12; i++) a[i] = s[32*i +: 32];
    for (int unsigned x = 0; x < 4; x++) p[x] = a[x] ^ a[x+4] ^ a[x+8];
    for (int unsigned x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
    for (int unsigned x = 0; x < 4; x++) begin
      b[x]   = a[x] ^ e[x];
      b[x+4] = a[4 + (x+3)%4] ^ e[(x+3)%4];
      b[x+8] = rotl(a[x+8] ^ e[x], 11);
    end
    b[0] = b[0] ^ c;
    for (int unsigned x = 0; x < 4; x++) begin
      a[x]   = b[x]   ^ (~b[x+4] & b[x+8]);
      a[x+4] = b[x+4] ^ (~b[x+8] & b[x]);
      a[x+8] = b[x+8] ^ (~b[x]   & b[x+4]);
    end
    r = '0;
    for (int unsigned x = 0; x < 4; x++) begin
      r[32*x +: 32]     = a[x];
      r[32*(x+4) +: 32] = rotl(a[x+4], 1);
      r[32*(x+8) +: 32] = rotl(a[8 + (x+2)%4], 8);
    end
    return r;
  endfunction

  always_comb begin
    perm_s = st_q;
    for (int unsigned k = 0; k < ROUNDS_PER_CYCLE; k++)
      perm_s = xoodoo_round(perm_s, rc(rnd_q + 4'(k)));
  end

  always_comb begin
    fsm_d      = fsm_q;
    st_d       = st_q;
    cnt_d      = cnt_q;
    ocnt_d     = ocnt_q;
    rnd_d      = rnd_q;
    first_d    = first_q;
    done_d     = done_q;
    msg_ready  = 1'b0;
    hash_valid = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        if (start) begin
          st_d    = '0;
          cnt_d   = '0;
          ocnt_d  = '0;
          rnd_d   = '0;
          first_d = 1'b1;
          done_d  = msg_empty;
          fsm_d   = msg_empty ? S_DOWN : S_ABSORB;
        end
      end
      S_ABSORB: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          st_d   = st_q ^ ({376'd0, msg_data} << {cnt_q, 3'b000});
          cnt_d  = cnt_q + 5'd1;
          done_d = msg_last;
          if (msg_last || cnt_q == 5'd15) fsm_d = S_DOWN;
        end
      end
      S_DOWN: begin
        // Pad byte at cnt (16 on a full block); hash-mode domain bit only on the first block.
        st_d    = st_q ^ ({383'd0, 1'b1} << {cnt_q, 3'b000}) ^ {7'd0, first_q, 376'd0};
        cnt_d   = '0;
        first_d = 1'b0;
        rnd_d   = '0;
        fsm_d   = S_PERM;
      end
      S_PERM: begin
        st_d  = perm_s;
        rnd_d = rnd_q + RND_STEP;
        if (rnd_q == RND_LAST) fsm_d = done_q ? S_SQUEEZE : S_ABSORB;
      end
      S_SQUEEZE: begin
        hash_valid = 1'b1;
        if (hash_ready) begin
          if (ocnt_q == OUT_LAST) begin
            fsm_d = S_IDLE;
`ifdef XOODYAK_ZEROIZE_EN
            st_d = '0;
`endif
          end else begin
            ocnt_d = ocnt_q + 8'd1;
            if (ocnt_q[3:0] == 4'hF) fsm_d = S_SDOWN;
          end
        end
      end
      S_SDOWN: begin
        st_d[0] = ~st_q[0];
        rnd_d   = '0;
        fsm_d   = S_PERM;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q   <= S_IDLE;
      st_q    <= '0;
      cnt_q   <= '0;
      ocnt_q  <= '0;
      rnd_q   <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      ocnt_q  <= ocnt_d;
      rnd_q   <= rnd_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
  end

  // ocnt is not advanced past the final byte, so hash_data keeps showing it in IDLE.
  assign hash_data = 8'(st_q >> {ocnt_q[3:0], 3'b000});
  assign hash_last = hash_valid && (ocnt_q == OUT_LAST);
  assign busy      = (fsm_q != S_IDLE);

endmodule
